// File: rtl/msg_modulator.sv
// Serial message modulator: latches a message on a send edge and shifts it out MSB-first,
// one programmable-length symbol per bit, as OOK, FSK, NRZ or Manchester.
module msg_modulator #(
  parameter int MSG_W = 5,
  parameter int DIV_W = 8,
  parameter int SYM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send,
  input  logic             abort,
  input  logic [MSG_W-1:0] msg,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div_hi,
  input  logic [DIV_W-1:0] div_lo,
  input  logic [SYM_W-1:0] sym_len,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;
  typedef enum logic [1:0] {M_OOK = 2'b00, M_FSK = 2'b01, M_NRZ = 2'b10, M_MAN = 2'b11} mode_t;

  state_t           state, state_n;
  logic             send_q;
  logic [MSG_W-1:0] msg_r, msg_n;
  mode_t            mode_r, mode_n;
  logic [DIV_W-1:0] div_hi_r, div_hi_n, div_lo_r, div_lo_n;
  logic [SYM_W-1:0] len_r, len_n, len_in;
  logic [BIT_W-1:0] bit_idx, bit_n;
  logic [SYM_W-1:0] sym_cnt, sym_n;
  logic [DIV_W-1:0] car_cnt, car_cnt_n, cur_div;
  logic             car_lvl, car_lvl_n;
  logic             out_n, drive, accept, bit_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      send_q   <= 1'b0;
      msg_r    <= '0;
      mode_r   <= M_OOK;
      div_hi_r <= '0;
      div_lo_r <= '0;
      len_r    <= '0;
      bit_idx  <= '0;
      sym_cnt  <= '0;
      car_cnt  <= '0;
      car_lvl  <= 1'b0;
      out      <= 1'b0;
    end else begin
      state    <= state_n;
      send_q   <= send;
      msg_r    <= msg_n;
      mode_r   <= mode_n;
      div_hi_r <= div_hi_n;
      div_lo_r <= div_lo_n;
      len_r    <= len_n;
      bit_idx  <= bit_n;
      sym_cnt  <= sym_n;
      car_cnt  <= car_cnt_n;
      car_lvl  <= car_lvl_n;
      out      <= out_n;
    end
  end

  assign busy = (state == S_SEND);
  assign done = (state == S_DONE);

  always_comb begin
    state_n   = state;
    msg_n     = msg_r;
    mode_n    = mode_r;
    div_hi_n  = div_hi_r;
    div_lo_n  = div_lo_r;
    len_n     = len_r;
    bit_n     = bit_idx;
    sym_n     = sym_cnt;
    car_cnt_n = car_cnt;
    car_lvl_n = car_lvl;
    drive     = 1'b0;
    out_n     = 1'b0;
    bit_v     = 1'b0;
    accept    = send && !send_q;

    len_in = (sym_len == '0) ? SYM_W'(1) : sym_len;
    if (mode_t'(mode) == M_MAN && len_in < SYM_W'(2))
      len_in = SYM_W'(2);

    cur_div = (mode_r == M_FSK && !msg_r[bit_idx]) ? div_lo_r : div_hi_r;

    // Everything is computed for the *next* cycle's symbol position so that
    // the registered output already shows the MSB's first cycle at accept.
    case (state)
      S_SEND: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (sym_cnt == len_r - SYM_W'(1)) begin
          if (bit_idx == '0) begin
            state_n = S_DONE;
          end else begin
            bit_n     = bit_idx - BIT_W'(1);
            sym_n     = '0;
            car_cnt_n = '0;
            car_lvl_n = 1'b1;
            drive     = 1'b1;
          end
        end else begin
          sym_n = sym_cnt + SYM_W'(1);
          if (car_cnt == cur_div) begin
            car_cnt_n = '0;
            car_lvl_n = ~car_lvl;
          end else begin
            car_cnt_n = car_cnt + DIV_W'(1);
          end
          drive = 1'b1;
        end
      end
      default: begin
        // A fresh edge sampled at the end of DONE is accepted directly.
        state_n = S_IDLE;
        if (accept) begin
          state_n   = S_SEND;
          msg_n     = msg;
          mode_n    = mode_t'(mode);
          div_hi_n  = div_hi;
          div_lo_n  = div_lo;
          len_n     = len_in;
          bit_n     = BIT_W'(MSG_W - 1);
          sym_n     = '0;
          car_cnt_n = '0;
          car_lvl_n = 1'b1;
          drive     = 1'b1;
        end
      end
    endcase

    if (drive) begin
      bit_v = msg_n[bit_n];
      case (mode_n)
        M_OOK:   out_n = bit_v & car_lvl_n;
        M_FSK:   out_n = car_lvl_n;
        M_NRZ:   out_n = bit_v;
        default: out_n = (sym_n < (len_n >> 1)) ? ~bit_v : bit_v;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_modulator.sv
// Directed bench for msg_modulator: table of per-mode symbol patterns plus
// hand-written abort, reset, handshake and 12-bit one-cycle-symbol sequences.
module tb_msg_modulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        send = 1'b0, send2 = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  msg = '0;
  logic [11:0] msg2 = '0;
  logic [1:0]  mode = '0;
  logic [7:0]  div_hi = '0, div_lo = '0;
  logic [15:0] sym_len = '0;
  logic        out, busy, done, out2, busy2, done2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  msg_modulator #(.MSG_W(5), .DIV_W(8), .SYM_W(16)) u_dut (
    .clk(clk), .rst(rst), .send(send), .abort(abort), .msg(msg), .mode(mode),
    .div_hi(div_hi), .div_lo(div_lo), .sym_len(sym_len),
    .out(out), .busy(busy), .done(done)
  );

  msg_modulator #(.MSG_W(12), .DIV_W(8), .SYM_W(16)) u_dut12 (
    .clk(clk), .rst(rst), .send(send2), .abort(abort), .msg(msg2), .mode(mode),
    .div_hi(div_hi), .div_lo(div_lo), .sym_len(sym_len),
    .out(out2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [4:0]  msg;
    logic [7:0]  dh;
    logic [7:0]  dl;
    logic [15:0] sl;
    int unsigned len;
    logic [15:0] p1;   // symbol for bit=1, first cycle in bit [len-1]
    logic [15:0] p0;   // symbol for bit=0
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic run_xfer(input logic [1:0] m, input logic [4:0] mg, input logic [7:0] dh,
                          input logic [7:0] dl, input logic [15:0] sl, input int unsigned len,
                          input logic [15:0] p1, input logic [15:0] p0, input bit hold);
    logic exp;
    @(negedge clk);
    mode = m; msg = mg; div_hi = dh; div_lo = dl; sym_len = sl; send = 1'b1;
    @(posedge clk); #1;
    for (int b = 4; b >= 0; b--) begin
      for (int unsigned c = 0; c < len; c++) begin
        exp = mg[b] ? p1[len-1-c] : p0[len-1-c];
        check("out", out, exp);
        check("busy", busy, 1'b1);
        check("done_low", done, 1'b0);
        if (b == 4 && c == 0) begin
          msg = ~mg; mode = ~m; div_hi = ~dh; div_lo = ~dl; sym_len = sl + 16'd3;
          if (!hold) send = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    check("done_pulse", done, 1'b1);
    check("busy_end", busy, 1'b0);
    check("out_end", out, 1'b0);
    for (int i = 0; i < (hold ? 4 : 1); i++) begin
      @(posedge clk); #1;
      check("done_once", done, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_out", out, 1'b0);
    end
    send = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    //            mode   msg       dh    dl    sl     L   p1                  p0
    vecs[0] = '{2'b10, 5'b10111, 8'd0, 8'd0, 16'd8, 8, 16'b11111111,       16'b00000000};
    vecs[1] = '{2'b00, 5'b10111, 8'd1, 8'd0, 16'd8, 8, 16'b11001100,       16'b00000000};
    vecs[2] = '{2'b01, 5'b10111, 8'd0, 8'd3, 16'd8, 8, 16'b10101010,       16'b11110000};
    vecs[3] = '{2'b11, 5'b10111, 8'd0, 8'd0, 16'd8, 8, 16'b00001111,       16'b11110000};
    vecs[4] = '{2'b11, 5'b10110, 8'd0, 8'd0, 16'd1, 2, 16'b01,             16'b10};
    vecs[5] = '{2'b10, 5'b01101, 8'd0, 8'd0, 16'd0, 1, 16'b1,              16'b0};
    vecs[6] = '{2'b01, 5'b01101, 8'd2, 8'd0, 16'd6, 6, 16'b111000,         16'b101010};
    vecs[7] = '{2'b00, 5'b11000, 8'd0, 8'd5, 16'd5, 5, 16'b10101,          16'b00000};
    vecs[8] = '{2'b11, 5'b10010, 8'd0, 8'd0, 16'd5, 5, 16'b00111,          16'b11000};

    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      run_xfer(vecs[i].mode, vecs[i].msg, vecs[i].dh, vecs[i].dl, vecs[i].sl,
               vecs[i].len, vecs[i].p1, vecs[i].p0, 1'b0);

    // Abort during the third cycle of bit 3, then restart with a new message.
    @(negedge clk);
    mode = 2'b10; msg = 5'b10111; sym_len = 16'd8; send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("abort_pre_out", out, (i < 8) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
    end
    check("abort_pre_busy", busy, 1'b1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_out", out, 1'b0);
    check("abort_done", done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", done, 1'b0);
      check("abort_idle", busy, 1'b0);
    end
    run_xfer(2'b10, 5'b01001, 8'd0, 8'd0, 16'd2, 2, 16'b11, 16'b00, 1'b0);

    // send held high through done must not start a second transfer.
    run_xfer(2'b10, 5'b11010, 8'd0, 8'd0, 16'd3, 3, 16'b111, 16'b000, 1'b1);

    // Asynchronous reset mid-symbol.
    @(negedge clk);
    mode = 2'b10; msg = 5'b11111; sym_len = 16'd8; send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("pre_rst_busy", busy, 1'b1);
    check("pre_rst_out", out, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_out", out, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_idle", busy, 1'b0);
    end

    // 12-bit instance, sym_len=0 gives one-cycle NRZ symbols.
    @(negedge clk);
    mode = 2'b10; sym_len = 16'd0; msg2 = 12'hA5C; send2 = 1'b1;
    @(posedge clk); #1;
    send2 = 1'b0;
    for (int i = 11; i >= 0; i--) begin
      check("w12_out", out2, msg2[i]);
      check("w12_busy", busy2, 1'b1);
      @(posedge clk); #1;
    end
    check("w12_done", done2, 1'b1);
    check("w12_busy_end", busy2, 1'b0);
    @(posedge clk); #1;
    check("w12_done_once", done2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
